// File: rtl/soccer_pkg.sv
// soccer_pkg
// Shared definitions for the soccer game blocks: playfield geometry used by
// the ball, player and referee controllers, the referee state encoding and
// the winner encoding reported to the score/HUD overlay.
package soccer_pkg;

  localparam int SCREEN_W  = 640;
  localparam int FLOOR_Y   = 400;
  localparam int GOAL_W    = 80;
  localparam int GOAL_H    = 150;
  localparam int BALL_SIZE = 20;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    GOAL_HOLD = 2'd2,
    OVER      = 2'd3
  } referee_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  // Winner decided from a pair of final scores; equal scores are a draw.
  function automatic winner_t calcWinner(input logic [3:0] s1, input logic [3:0] s2);
    if (s1 > s2)      return WIN_P1;
    else if (s2 > s1) return WIN_P2;
    else              return WIN_DRAW;
  endfunction

endpackage

// File: rtl/match_timer.sv
// match_timer
// Match clock for the referee: a frame divider that produces one tick per
// second while running, and a seconds down-counter that stops at zero.
// Ports:
//   frame_clk  in   vsync-rate clock
//   Reset_n    in   synchronous active-low reset
//   run        in   advance the divider this frame
//   clear      in   reload the full match length and zero the divider
//   TimeLeft   out  seconds remaining (registered)
//   expire     out  high on the frame whose tick takes TimeLeft to zero
module match_timer #(
  parameter int MATCH_SECS     = 60,
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       run,
  input  logic       clear,
  output logic [6:0] TimeLeft,
  output logic       expire
);

  localparam int DIV_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  logic [DIV_W-1:0] r_div;
  logic [6:0]       r_time;
  logic             w_wrap;

  // A second elapses on the frame where the divider sits at its last count.
  // expire is decoded from the same condition so the parent can leave PLAY on
  // the very edge that brings the clock to zero.
  always_comb begin
    w_wrap = run && (r_div == DIV_W'(FRAMES_PER_SEC - 1));
    expire = w_wrap && (r_time == 7'd1);
  end

  // Divider and seconds counter. Once at zero the counter holds rather than
  // wrapping, and clear takes priority over running.
  always_ff @(posedge frame_clk) begin
    if (!Reset_n || clear) begin
      r_div  <= '0;
      r_time <= 7'(MATCH_SECS);
    end else if (run) begin
      if (w_wrap) begin
        r_div <= '0;
        if (r_time != 7'd0) r_time <= r_time - 7'd1;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  assign TimeLeft = r_time;

endmodule

// File: rtl/goal_referee.sv
// goal_referee
// Watches the ball each frame, awards goals, keeps both scores, runs the
// match clock and holds the ball in reset around kick-off and after goals.
// Ports:
//   frame_clk  in   vsync-rate clock, sole clock
//   Reset_n    in   synchronous active-low reset
//   Start      in   kick-off / restart request (level)
//   BallX/Y/S  in   ball left x, top y and size from ball physics
//   BallReset  out  active-high reset to ball physics
//   Score1/2   out  player goals (P1 defends left, P2 defends right)
//   TimeLeft   out  seconds remaining
//   GoalFlash  out  high while the ball is held after a goal
//   GameOver   out  high once the match has ended
//   Winner     out  00 none, 01 P1, 10 P2, 11 draw
module goal_referee
  import soccer_pkg::*;
#(
  parameter int WIN_SCORE      = 5,
  parameter int MATCH_SECS     = 60,
  parameter int FRAMES_PER_SEC = 60,
  parameter int HOLD_FRAMES    = 90
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  output logic       BallReset,
  output logic [3:0] Score1,
  output logic [3:0] Score2,
  output logic [6:0] TimeLeft,
  output logic       GoalFlash,
  output logic       GameOver,
  output logic [1:0] Winner
);

  referee_state_t r_state;
  logic [3:0]     r_score1;
  logic [3:0]     r_score2;
  logic [6:0]     r_hold;
  logic           r_ballReset;
  logic           r_goalFlash;
  logic           r_gameOver;
  winner_t        r_winner;

  logic [10:0] w_ballRight;
  logic        w_leftGoal;
  logic        w_rightGoal;
  logic        w_goal;
  logic [3:0]  w_newScore1;
  logic [3:0]  w_newScore2;
  logic        w_matchEnd;
  logic        w_timerRun;
  logic        w_timerClear;
  logic        w_expire;

  match_timer #(
    .MATCH_SECS    (MATCH_SECS),
    .FRAMES_PER_SEC(FRAMES_PER_SEC)
  ) u_timer (
    .frame_clk(frame_clk),
    .Reset_n  (Reset_n),
    .run      (w_timerRun),
    .clear    (w_timerClear),
    .TimeLeft (TimeLeft),
    .expire   (w_expire)
  );

  // Goal geometry and the scores that would result from this frame. The
  // right edge is formed in 11 bits so a large x plus size cannot wrap round
  // into the left goal mouth. A left-goal sighting is preferred if both ever
  // appear, and scores saturate at 15.
  always_comb begin
    w_ballRight  = {1'b0, BallX} + {1'b0, BallS};
    w_leftGoal   = (w_ballRight <= 11'(GOAL_W)) && (BallY >= 10'(FLOOR_Y - GOAL_H));
    w_rightGoal  = (BallX >= 10'(SCREEN_W - GOAL_W)) && (BallY >= 10'(FLOOR_Y - GOAL_H));
    w_newScore1  = r_score1;
    w_newScore2  = r_score2;
    w_goal       = 1'b0;
    if (r_state == PLAY) begin
      if (w_leftGoal) begin
        w_goal      = 1'b1;
        w_newScore2 = (r_score2 == 4'd15) ? 4'd15 : r_score2 + 4'd1;
      end else if (w_rightGoal) begin
        w_goal      = 1'b1;
        w_newScore1 = (r_score1 == 4'd15) ? 4'd15 : r_score1 + 4'd1;
      end
    end
    w_matchEnd   = (w_newScore1 == 4'(WIN_SCORE)) || (w_newScore2 == 4'(WIN_SCORE)) || w_expire;
    w_timerRun   = (r_state == PLAY);
    w_timerClear = (r_state == OVER) && Start;
  end

  // Referee state machine with all outputs registered alongside the state.
  // Match end is checked before the plain goal case so a winning goal, or a
  // goal on the final frame, goes straight to OVER with the updated scores.
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_score1    <= 4'd0;
      r_score2    <= 4'd0;
      r_hold      <= 7'd0;
      r_ballReset <= 1'b1;
      r_goalFlash <= 1'b0;
      r_gameOver  <= 1'b0;
      r_winner    <= WIN_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          r_ballReset <= 1'b1;
          if (Start) begin
            r_state     <= PLAY;
            r_ballReset <= 1'b0;
          end
        end
        PLAY: begin
          r_score1 <= w_newScore1;
          r_score2 <= w_newScore2;
          if (w_matchEnd) begin
            r_state     <= OVER;
            r_ballReset <= 1'b1;
            r_goalFlash <= 1'b0;
            r_gameOver  <= 1'b1;
            r_winner    <= calcWinner(w_newScore1, w_newScore2);
          end else if (w_goal) begin
            r_state     <= GOAL_HOLD;
            r_ballReset <= 1'b1;
            r_goalFlash <= 1'b1;
            r_hold      <= 7'd0;
          end
        end
        GOAL_HOLD: begin
          if (r_hold == 7'(HOLD_FRAMES - 1)) begin
            r_state     <= PLAY;
            r_ballReset <= 1'b0;
            r_goalFlash <= 1'b0;
          end else begin
            r_hold <= r_hold + 7'd1;
          end
        end
        OVER: begin
          if (Start) begin
            r_state     <= IDLE;
            r_score1    <= 4'd0;
            r_score2    <= 4'd0;
            r_ballReset <= 1'b1;
            r_gameOver  <= 1'b0;
            r_winner    <= WIN_NONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign BallReset = r_ballReset;
  assign Score1    = r_score1;
  assign Score2    = r_score2;
  assign GoalFlash = r_goalFlash;
  assign GameOver  = r_gameOver;
  assign Winner    = r_winner;

endmodule

// File: doc/goal_referee.md
Name: goal_referee

Overview:
- Consumes the ball position produced by the ball physics block each frame.
- Decides goals, keeps both scores, and runs the match clock.
- Drives the ball physics reset (BallReset) back to it, so the ball re-centres after a goal and before kick-off.
- Sits beside the ball and player controllers on frame_clk; feeds the score/HUD overlay.

Parameters:
- SCREEN_W, 640, playfield width in pixels
- FLOOR_Y, 400, floor line y
- GOAL_W, 80, goal mouth depth from each side wall
- GOAL_H, 150, goal height; crossbar at FLOOR_Y-GOAL_H = 250
- WIN_SCORE, 5, first player to reach this wins (must be ≤ 15)
- MATCH_SECS, 60, match length in seconds
- FRAMES_PER_SEC, 60, frame_clk ticks per second
- HOLD_FRAMES, 90, frames the ball is frozen after a goal

Ports:
- frame_clk  in  1  vsync-rate clock, sole clock
- Reset_n  in  1  synchronous, active-low reset
- Start  in  1  level, sampled each frame; kick-off / restart request
- BallX  in  10  ball left x from ball physics
- BallY  in  10  ball top y
- BallS  in  10  ball size
- BallReset  out  1  to ball physics Reset (active-high)
- Score1  out  4  player 1 goals (player 1 defends the left goal)
- Score2  out  4  player 2 goals (player 2 defends the right goal)
- TimeLeft  out  7  seconds remaining
- GoalFlash  out  1  high during GOAL_HOLD
- GameOver  out  1  high in OVER
- Winner  out  2  00 none, 01 P1, 10 P2, 11 draw

Behaviour:
- Interface: one clock (frame_clk); Reset_n synchronous active-low. All outputs are registered.
- Reset (Reset_n=0 at an edge):
  - state=IDLE, Score1=Score2=0, TimeLeft=MATCH_SECS.
  - BallReset=1, GoalFlash=0, GameOver=0, Winner=00.
  - Frame divider and hold counter = 0.
  - Reset mid-operation aborts any state to this.
- Goal geometry uses ≥11-bit unsigned arithmetic, so there is no 10-bit overflow.
  - LeftGoal = (BallX+BallS ≤ GOAL_W) && (BallY ≥ FLOOR_Y-GOAL_H).
  - RightGoal = (BallX ≥ SCREEN_W-GOAL_W) && (BallY ≥ FLOOR_Y-GOAL_H).
  - A ball straddling the post or above the crossbar is not a goal.
- FSM states: IDLE, PLAY, GOAL_HOLD, OVER.
- IDLE:
  - BallReset=1; timer frozen.
  - Start=1 → PLAY; BallReset=0 from the next edge.
- PLAY:
  - BallReset=0.
  - Frame divider counts 0..FRAMES_PER_SEC-1; on wrap, TimeLeft decrements.
  - LeftGoal → Score2+1. RightGoal → Score1+1. Both are impossible geometrically; if both are seen, LeftGoal wins.
  - On a goal: next state GOAL_HOLD, BallReset=1, GoalFlash=1, hold counter cleared. Latency is one frame: the score and BallReset change on the edge after the sample.
  - Game end: if the updated score = WIN_SCORE, or TimeLeft reaches 0 on this frame, go to OVER instead.
  - A goal and timer expiry on the same frame: the goal counts first, then OVER is entered with the updated scores.
- GOAL_HOLD:
  - BallReset=1, GoalFlash=1; timer and divider frozen; goal inputs ignored.
  - Hold counter increments each frame; when it reaches HOLD_FRAMES-1 → PLAY, with BallReset=0 and GoalFlash=0 on that edge.
  - The ball is therefore held HOLD_FRAMES frames.
- OVER:
  - GameOver=1, BallReset=1; goals ignored; TimeLeft held.
  - Winner is computed on entry: Score1>Score2 → 01, Score2>Score1 → 10, equal → 11.
  - Start=1 → IDLE, with scores cleared, TimeLeft=MATCH_SECS, Winner=00, GameOver=0.
- Start is ignored in PLAY and GOAL_HOLD.
- Scores saturate at 15. TimeLeft never underflows below 0.

Decomposition:
- Shared package soccer_pkg holds:
  - field constants SCREEN_W, FLOOR_Y, GOAL_W, GOAL_H, BALL_SIZE (shared with the ball and player controllers);
  - the referee_state_t enum {IDLE, PLAY, GOAL_HOLD, OVER};
  - the winner_t encoding.
- Sub-module match_timer: frame divider plus seconds down-counter.
  - Inputs: run, clear.
  - Outputs: TimeLeft, expire (a single-frame strobe on the tick that reaches 0).
  - Same clock and reset as the parent.

Test Plan:
1. Reset_n=0 for 2 frames, then 1 → Score1=Score2=0, TimeLeft=60, BallReset=1, GameOver=0, Winner=00, state IDLE.
2. Start=1 one frame, ball at (310,190,20) → BallReset=0 next edge; after 60 further frames TimeLeft=59, no score change.
3. In PLAY, ball (30,380,20) → next edge Score2=1, BallReset=1, GoalFlash=1 for exactly 90 frames, then PLAY with BallReset=0; TimeLeft unchanged across the hold.
4. Non-goals in PLAY:
   - ball (30,200) above the crossbar → no score;
   - ball (70,380), where 70+20>80 straddles the post → no score;
   - ball (560,380), where 560<560 is false... but 560≥560 is true → Score1+1; ball (559,380) → no score.
5. Right goals (570,380) five times, with holds between → after the 5th, GameOver=1, Winner=01, Score1=5; further goal positions and Start=0 cause no change; Start=1 → IDLE, scores 0, TimeLeft=60.
6. Run the clock to expiry:
   - at 2-2 → Winner=11;
   - repeat with ball (30,380) on the expiry frame → Score2=3, Winner=10, GameOver=1.
